// File: rtl/led_seq_ctrl.sv
// RGB LED colour sequencer: walks a fixed 6-colour pattern with timed steps,
// optional all-off gaps between steps, and PWM brightness latched at start.
module led_seq_ctrl #(
  parameter int p_step_cycles = 12_000_000,
  parameter int p_gap_cycles  = 1_200_000,
  parameter int p_loops       = 0,
  parameter int p_pwm_bits    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [p_pwm_bits-1:0] i_duty,
  output logic                  o_led_r,
  output logic                  o_led_g,
  output logic                  o_led_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            o_step
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // One timer serves both RUN and GAP, so it is sized for the longer of the two.
  localparam int max_cycles = (p_step_cycles > p_gap_cycles) ? p_step_cycles : p_gap_cycles;
  localparam int tw         = (max_cycles > 1) ? $clog2(max_cycles) : 1;
  localparam int lw         = (p_loops > 0) ? $clog2(p_loops + 1) : 1;
  localparam bit has_gap    = (p_gap_cycles > 0);
  localparam bit has_loops  = (p_loops > 0);

  localparam logic [tw-1:0]         step_last = tw'(p_step_cycles - 1);
  localparam logic [tw-1:0]         gap_last  = tw'((p_gap_cycles > 0) ? p_gap_cycles - 1 : 0);
  localparam logic [lw-1:0]         loop_last = lw'((p_loops > 0) ? p_loops - 1 : 0);
  localparam logic [tw-1:0]         timer_one = tw'(1);
  localparam logic [lw-1:0]         loop_one  = lw'(1);
  localparam logic [p_pwm_bits-1:0] pwm_one   = p_pwm_bits'(1);

  state_t                  state_q;
  state_t                  state_d;
  logic [2:0]              step_q;
  logic [lw-1:0]           loop_q;
  logic [tw-1:0]           timer_q;
  logic [p_pwm_bits-1:0]   pwm_q;
  logic [p_pwm_bits-1:0]   duty_q;

  logic                    accept_start;
  logic                    run_end;
  logic                    gap_end;
  logic                    advance;
  logic                    last_step;
  logic                    finish;
  logic [2:0]              mask;
  logic                    pwm_on;

  assign accept_start = i_start & ~i_stop;
  assign run_end      = (state_q == RUN) && (timer_q == step_last);
  assign gap_end      = (state_q == GAP) && (timer_q == gap_last);
  assign advance      = (run_end && !has_gap) || gap_end;
  assign last_step    = (step_q == 3'd5);
  // Only a finite sequence ever finishes; with p_loops=0 the loop count is ignored.
  assign finish       = advance && last_step && has_loops && (loop_q == loop_last);
  assign pwm_on       = (pwm_q < duty_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (run_end) begin
          if (has_gap) begin
            state_d = GAP;
          end else if (finish) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      GAP: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (gap_end) begin
          state_d = finish ? DONE : RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Step/loop/timer/PWM bookkeeping; timer and pwm_cnt restart on every RUN entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      step_q  <= 3'd0;
      loop_q  <= '0;
      timer_q <= '0;
      pwm_q   <= '0;
      duty_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_start) begin
            step_q  <= 3'd0;
            loop_q  <= '0;
            timer_q <= '0;
            pwm_q   <= '0;
            duty_q  <= i_duty;
          end
        end
        RUN, GAP: begin
          if (i_stop) begin
            step_q  <= 3'd0;
            timer_q <= '0;
            pwm_q   <= '0;
          end else if (advance) begin
            timer_q <= '0;
            pwm_q   <= '0;
            if (last_step) begin
              step_q <= 3'd0;
              loop_q <= loop_q + loop_one;
            end else begin
              step_q <= step_q + 3'd1;
            end
          end else if (run_end) begin
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + timer_one;
            if (state_q == RUN) begin
              pwm_q <= pwm_q + pwm_one;
            end
          end
        end
        default: begin
          step_q <= step_q;
        end
      endcase
    end
  end

  always_comb begin
    mask = 3'b000;
    case (step_q)
      3'd0:    mask = 3'b100;
      3'd1:    mask = 3'b110;
      3'd2:    mask = 3'b010;
      3'd3:    mask = 3'b011;
      3'd4:    mask = 3'b001;
      3'd5:    mask = 3'b101;
      default: mask = 3'b000;
    endcase
  end

  always_comb begin
    o_led_r = 1'b0;
    o_led_g = 1'b0;
    o_led_b = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    o_step  = step_q;
    case (state_q)
      RUN: begin
        o_led_r = mask[2] & pwm_on;
        o_led_g = mask[1] & pwm_on;
        o_led_b = mask[0] & pwm_on;
        o_busy  = 1'b1;
      end
      GAP: begin
        o_busy = 1'b1;
      end
      DONE: begin
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: three instances cover the finite, repeating
// and gap-less configurations; each scenario task checks outputs every cycle.
module tb_led_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A: step 8, gap 2, one loop
  logic       a_rst, a_start, a_stop;
  logic [1:0] a_duty;
  logic       a_r, a_g, a_b, a_busy, a_done;
  logic [2:0] a_step;
  // Instance B: repeat forever
  logic       b_rst, b_start, b_stop;
  logic [1:0] b_duty;
  logic       b_r, b_g, b_b, b_busy, b_done;
  logic [2:0] b_step;
  // Instance C: no gap
  logic       c_rst, c_start, c_stop;
  logic [1:0] c_duty;
  logic       c_r, c_g, c_b, c_busy, c_done;
  logic [2:0] c_step;

  led_seq_ctrl #(.p_step_cycles(8), .p_gap_cycles(2), .p_loops(1), .p_pwm_bits(2)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .i_stop(a_stop), .i_duty(a_duty),
    .o_led_r(a_r), .o_led_g(a_g), .o_led_b(a_b), .o_busy(a_busy), .o_done(a_done), .o_step(a_step)
  );

  led_seq_ctrl #(.p_step_cycles(8), .p_gap_cycles(2), .p_loops(0), .p_pwm_bits(2)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_stop(b_stop), .i_duty(b_duty),
    .o_led_r(b_r), .o_led_g(b_g), .o_led_b(b_b), .o_busy(b_busy), .o_done(b_done), .o_step(b_step)
  );

  led_seq_ctrl #(.p_step_cycles(8), .p_gap_cycles(0), .p_loops(1), .p_pwm_bits(2)) dut_c (
    .i_clk(clk), .i_rst(c_rst), .i_start(c_start), .i_stop(c_stop), .i_duty(c_duty),
    .o_led_r(c_r), .o_led_g(c_g), .o_led_b(c_b), .o_busy(c_busy), .o_done(c_done), .o_step(c_step)
  );

  wire [7:0] a_vec = {a_r, a_g, a_b, a_busy, a_done, a_step};
  wire [7:0] b_vec = {b_r, b_g, b_b, b_busy, b_done, b_step};
  wire [7:0] c_vec = {c_r, c_g, c_b, c_busy, c_done, c_step};

  // Expected {r,g,b,busy,done,step} at cycle c after a start in cycle 0 (step=8 clocks).
  function automatic logic [7:0] exp_vec(input int c, input int duty, input int gap, input bit repeat_mode);
    int period;
    int total;
    int t;
    int k;
    int off;
    logic [2:0] m;
    logic [2:0] leds;
    period = 8 + gap;
    total  = 6 * period;
    if (c < 1) return 8'h00;
    if (!repeat_mode && c == total + 1) return 8'b000_0_1_000;
    if (!repeat_mode && c > total + 1) return 8'h00;
    t   = (c - 1) % total;
    k   = t / period;
    off = t % period;
    case (k)
      0: m = 3'b100;
      1: m = 3'b110;
      2: m = 3'b010;
      3: m = 3'b011;
      4: m = 3'b001;
      default: m = 3'b101;
    endcase
    leds = 3'b000;
    if (off < 8 && (off % 4) < duty) leds = m;
    return {leds, 1'b1, 1'b0, 3'(k)};
  endfunction

  task automatic test_reset();
    a_rst = 1; a_start = 0; a_stop = 0; a_duty = 0;
    b_rst = 1; b_start = 0; b_stop = 0; b_duty = 0;
    c_rst = 1; c_start = 0; c_stop = 0; c_duty = 0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (a_vec !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_a: got %b expected %b", a_vec, 8'h00); end
    vectors++;
    if (b_vec !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_b: got %b expected %b", b_vec, 8'h00); end
    vectors++;
    if (c_vec !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_c: got %b expected %b", c_vec, 8'h00); end
    a_rst = 0; b_rst = 0; c_rst = 0;
    @(posedge clk); #1;
    vectors++;
    if (a_vec !== 8'h00) begin miscompares++; $display("[TB] FAIL post_reset_a: got %b expected %b", a_vec, 8'h00); end
  endtask

  task automatic test_full_duty3();
    logic [7:0] e;
    @(posedge clk); #1;
    a_duty = 3; a_start = 1;
    for (int c = 1; c <= 62; c++) begin
      @(posedge clk); #1;
      a_start = 0;
      a_duty  = 0;
      e = exp_vec(c, 3, 2, 1'b0);
      vectors++;
      if (a_vec !== e) begin
        miscompares++;
        $display("[TB] FAIL duty3 cycle %0d: got %b expected %b", c, a_vec, e);
      end
    end
  endtask

  task automatic test_duty_zero();
    logic [7:0] e;
    @(posedge clk); #1;
    a_duty = 0; a_start = 1;
    for (int c = 1; c <= 62; c++) begin
      @(posedge clk); #1;
      a_start = 0;
      a_duty  = 3;
      e = exp_vec(c, 0, 2, 1'b0);
      vectors++;
      if (a_vec !== e) begin
        miscompares++;
        $display("[TB] FAIL duty0 cycle %0d: got %b expected %b", c, a_vec, e);
      end
    end
  endtask

  task automatic test_stop();
    logic [7:0] e;
    @(posedge clk); #1;
    a_duty = 3; a_start = 1;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      a_start = (c == 20 || c == 25);
      a_stop  = (c == 20 || c == 30);
      if (c <= 20)      e = exp_vec(c, 3, 2, 1'b0);
      else if (c <= 25) e = 8'h00;
      else if (c <= 30) e = exp_vec(c - 25, 3, 2, 1'b0);
      else              e = 8'h00;
      vectors++;
      if (a_vec !== e) begin
        miscompares++;
        $display("[TB] FAIL stop cycle %0d: got %b expected %b", c, a_vec, e);
      end
    end
    a_start = 0; a_stop = 0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    @(posedge clk); #1;
    a_duty = 3; a_start = 1;
    for (int c = 1; c <= 95; c++) begin
      @(posedge clk); #1;
      a_rst   = (c >= 30 && c <= 32);
      a_start = (c == 33);
      if (c <= 30)      e = exp_vec(c, 3, 2, 1'b0);
      else if (c <= 33) e = 8'h00;
      else              e = exp_vec(c - 33, 3, 2, 1'b0);
      vectors++;
      if (a_vec !== e) begin
        miscompares++;
        $display("[TB] FAIL reset_mid cycle %0d: got %b expected %b", c, a_vec, e);
      end
    end
    a_start = 0; a_rst = 0;
  endtask

  task automatic test_start_stop_idle();
    @(posedge clk); #1;
    a_duty = 3;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      a_start = (c == 1);
      a_stop  = (c == 1);
      vectors++;
      if (a_vec !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL start_stop_idle cycle %0d: got %b expected %b", c, a_vec, 8'h00);
      end
    end
    a_start = 0; a_stop = 0;
  endtask

  task automatic test_forever();
    logic [7:0] e;
    @(posedge clk); #1;
    b_duty = 3; b_start = 1;
    for (int c = 1; c <= 131; c++) begin
      @(posedge clk); #1;
      b_start = (c == 15 || c == 40);
      b_stop  = (c == 130);
      e = (c == 131) ? 8'h00 : exp_vec(c, 3, 2, 1'b1);
      vectors++;
      if (b_vec !== e) begin
        miscompares++;
        $display("[TB] FAIL forever cycle %0d: got %b expected %b", c, b_vec, e);
      end
    end
    b_start = 0; b_stop = 0;
  endtask

  task automatic test_no_gap();
    logic [7:0] e;
    @(posedge clk); #1;
    c_duty = 2; c_start = 1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      c_start = 0;
      e = exp_vec(c, 2, 0, 1'b0);
      vectors++;
      if (c_vec !== e) begin
        miscompares++;
        $display("[TB] FAIL no_gap cycle %0d: got %b expected %b", c, c_vec, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_duty3();
    test_duty_zero();
    test_stop();
    test_reset_mid();
    test_start_stop_idle();
    test_forever();
    test_no_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
